// File: rtl/return_addr_stack_pkg.sv
// Shared processor package: PC/instruction widths, the return-address stack
// depth, the pc3 next-PC mux select encodings, and the stack's per-edge
// operation code.
package return_addr_stack_pkg;

   localparam int PC_W      = 12;
   localparam int INSTR_W   = 19;
   localparam int RAS_DEPTH = 8;
   localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

   // pc3 next-PC mux select: the RET leg is fed by top_addr.
   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] PC_JUMP = 2'd1;
   localparam logic [1:0] PC_RET  = 2'd2;

   // Encoding matches the {push, pop} concatenation so the decode is a cast.
   typedef enum logic [1:0] {
      RAS_NOP  = 2'b00,
      RAS_POP  = 2'b01,
      RAS_PUSH = 2'b10,
      RAS_REPL = 2'b11
   } ras_op_e;

endpackage

// File: rtl/return_addr_stack_if.sv
// Controller <-> return-address stack bundle.
//   master (controller): drives push, pop, push_addr, err_clr; reads status.
//   slave  (stack)     : reads the commands; drives top_addr, empty, full,
//                        count, overflow, underflow.
interface return_addr_stack_if
   import return_addr_stack_pkg::*;
#(
   parameter int ADDR_W = PC_W,
   parameter int CNT_W  = RAS_CNT_W
);
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_addr;
   logic              err_clr;
   logic [ADDR_W-1:0] top_addr;
   logic              empty;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, push_addr, err_clr,
      input  top_addr, empty, full, count, overflow, underflow
   );

   modport slave (
      input  push, pop, push_addr, err_clr,
      output top_addr, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/return_addr_stack_ras_regfile.sv
// Stack storage: DEPTH x ADDR_W registers, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
module ras_regfile
   import return_addr_stack_pkg::*;
#(
   parameter int ADDR_W = PC_W,
   parameter int DEPTH  = RAS_DEPTH,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [ADDR_W-1:0] rdata
);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Hardware return-address stack for the single-cycle processor. CALL pushes
// the return PC, RET pops it; top_addr is combinational so RET can steer the
// pc3 mux in the same cycle it pops.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset of count and sticky flags
//   bus : slave side of return_addr_stack_if
//         push/pop/push_addr/err_clr in; top_addr/empty/full/count/
//         overflow/underflow out
module return_addr_stack
   import return_addr_stack_pkg::*;
#(
   parameter int ADDR_W = PC_W,
   parameter int DEPTH  = RAS_DEPTH,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   return_addr_stack_if.slave bus
);

   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              is_empty, is_full;
   logic              we;
   logic [IDX_W-1:0]  waddr;
   logic [IDX_W-1:0]  top_idx;
   logic [ADDR_W-1:0] rdata;
   ras_op_e           op;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_C);
   assign op       = ras_op_e'({bus.push, bus.pop});

   // Index of the current top. For count in 1..DEPTH the low bits minus one
   // wrap to the right slot (count==DEPTH -> DEPTH-1); the empty case is
   // masked at the output.
   assign top_idx  = count_q[IDX_W-1:0] - IDX_W'(1);

   always_comb begin
      count_d     = count_q;
      // A new error in the same cycle re-sets the flag below, so it wins.
      overflow_d  = overflow_q  & ~bus.err_clr;
      underflow_d = underflow_q & ~bus.err_clr;
      we          = 1'b0;
      waddr       = top_idx;

      unique case (op)
         RAS_PUSH: begin
            if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               we      = 1'b1;
               waddr   = count_q[IDX_W-1:0];
               count_d = count_q + CNT_W'(1);
            end
         end
         RAS_POP: begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         RAS_REPL: begin
            // Replace the top in place; on an empty stack this degrades to a
            // plain push into slot 0 while still flagging the missing pop.
            we = 1'b1;
            if (is_empty) begin
               waddr       = '0;
               count_d     = CNT_W'(1);
               underflow_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   ras_regfile #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (bus.push_addr),
      .raddr (top_idx),
      .rdata (rdata)
   );

   assign bus.top_addr  = is_empty ? '0 : rdata;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;
   import return_addr_stack_pkg::*;

   localparam int AW = 12;
   localparam int DP = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   return_addr_stack_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

   return_addr_stack #(.ADDR_W(AW), .DEPTH(DP), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: the stack is a plain queue, flags are bits.
   logic [AW-1:0] model_q[$];
   bit            m_ovf, m_unf;
   logic [AW-1:0] pre_top;

   function automatic logic [AW-1:0] model_top();
      return (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
   endfunction

   task automatic model_step(input bit p, input bit q, input logic [AW-1:0] a,
                             input bit c, input bit r);
      bit new_ovf = 0;
      bit new_unf = 0;
      if (r) begin
         model_q.delete();
         m_ovf = 0;
         m_unf = 0;
         return;
      end
      if (p && q) begin
         if (model_q.size() == 0) begin
            model_q.push_back(a);
            new_unf = 1;
         end else begin
            model_q[model_q.size()-1] = a;
         end
      end else if (p) begin
         if (model_q.size() == DP) new_ovf = 1;
         else model_q.push_back(a);
      end else if (q) begin
         if (model_q.size() == 0) new_unf = 1;
         else void'(model_q.pop_back());
      end
      m_ovf = new_ovf | (m_ovf & !c);
      m_unf = new_unf | (m_unf & !c);
   endtask

   // One clock: drive inputs, sample the combinational top mid-cycle,
   // then clock and leave the bench #1 after the edge.
   task automatic apply(input bit p, input bit q, input logic [AW-1:0] a,
                        input bit c, input bit r);
      bus.push = p; bus.pop = q; bus.push_addr = a; bus.err_clr = c; rst = r;
      #1;
      pre_top = bus.top_addr;
      @(posedge clk);
      model_step(p, q, a, c, r);
      #1;
      bus.push = 0; bus.pop = 0; bus.err_clr = 0; rst = 0;
   endtask

   task automatic do_reset();
      apply(0, 0, '0, 0, 1);
      apply(0, 0, '0, 0, 1);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({bus.count, bus.empty, bus.full, bus.overflow, bus.underflow} !== {4'd0, 4'b1000}) begin
         n_miss++;
         $display("FAIL reset_status got cnt=%0d e=%b f=%b o=%b u=%b want cnt=0 e=1 f=0 o=0 u=0",
                  bus.count, bus.empty, bus.full, bus.overflow, bus.underflow);
      end
      n_vec++;
      if (bus.top_addr !== 12'h000) begin
         n_miss++;
         $display("FAIL reset_top got %h want 000", bus.top_addr);
      end
   endtask

   task automatic test_lifo();
      logic [AW-1:0] exp_v;
      do_reset();
      apply(1, 0, 12'h010, 0, 0);
      apply(1, 0, 12'h020, 0, 0);
      apply(1, 0, 12'h030, 0, 0);
      n_vec++;
      if ({bus.count, bus.top_addr} !== {4'd3, 12'h030}) begin
         n_miss++;
         $display("FAIL lifo_push got cnt=%0d top=%h want cnt=3 top=030", bus.count, bus.top_addr);
      end
      for (int i = 0; i < 3; i++) begin
         exp_v = 12'h030 - 12'(i * 16);
         apply(0, 1, '0, 0, 0);
         n_vec++;
         if (pre_top !== exp_v) begin
            n_miss++;
            $display("FAIL lifo_pop%0d got %h want %h", i, pre_top, exp_v);
         end
      end
      n_vec++;
      if ({bus.empty, bus.count, bus.underflow} !== {1'b1, 4'd0, 1'b0}) begin
         n_miss++;
         $display("FAIL lifo_empty got e=%b cnt=%0d u=%b want e=1 cnt=0 u=0",
                  bus.empty, bus.count, bus.underflow);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) apply(1, 0, 12'h100 + 12'(i), 0, 0);
      n_vec++;
      if ({bus.full, bus.count, bus.top_addr, bus.overflow} !== {1'b1, 4'd8, 12'h107, 1'b0}) begin
         n_miss++;
         $display("FAIL full_fill got f=%b cnt=%0d top=%h o=%b want f=1 cnt=8 top=107 o=0",
                  bus.full, bus.count, bus.top_addr, bus.overflow);
      end
      apply(1, 0, 12'h1FF, 0, 0);
      n_vec++;
      if ({bus.count, bus.top_addr, bus.overflow} !== {4'd8, 12'h107, 1'b1}) begin
         n_miss++;
         $display("FAIL full_ovf got cnt=%0d top=%h o=%b want cnt=8 top=107 o=1",
                  bus.count, bus.top_addr, bus.overflow);
      end
      apply(1, 1, 12'h2AA, 0, 0);
      n_vec++;
      if ({bus.count, bus.top_addr, bus.overflow, bus.underflow} !== {4'd8, 12'h2AA, 1'b1, 1'b0}) begin
         n_miss++;
         $display("FAIL full_repl got cnt=%0d top=%h o=%b u=%b want cnt=8 top=2aa o=1 u=0",
                  bus.count, bus.top_addr, bus.overflow, bus.underflow);
      end
      // Unwind: entries below the replaced top are intact.
      apply(0, 1, '0, 0, 0);
      n_vec++;
      if ({pre_top, bus.top_addr} !== {12'h2AA, 12'h106}) begin
         n_miss++;
         $display("FAIL full_unwind got pop=%h top=%h want pop=2aa top=106", pre_top, bus.top_addr);
      end
   endtask

   task automatic test_empty();
      do_reset();
      apply(0, 1, '0, 0, 0);
      n_vec++;
      if ({bus.count, bus.underflow, bus.overflow} !== {4'd0, 1'b1, 1'b0}) begin
         n_miss++;
         $display("FAIL empty_pop got cnt=%0d u=%b o=%b want cnt=0 u=1 o=0",
                  bus.count, bus.underflow, bus.overflow);
      end
      apply(0, 0, '0, 0, 0);
      n_vec++;
      if (bus.underflow !== 1'b1) begin
         n_miss++;
         $display("FAIL empty_sticky got u=%b want 1", bus.underflow);
      end
      apply(0, 0, '0, 1, 0);
      n_vec++;
      if (bus.underflow !== 1'b0) begin
         n_miss++;
         $display("FAIL empty_clr got u=%b want 0", bus.underflow);
      end
      apply(0, 1, '0, 1, 0);
      n_vec++;
      if ({bus.underflow, bus.count} !== {1'b1, 4'd0}) begin
         n_miss++;
         $display("FAIL empty_clr_err got u=%b cnt=%0d want u=1 cnt=0", bus.underflow, bus.count);
      end
   endtask

   task automatic test_simul_empty();
      do_reset();
      apply(1, 1, 12'h055, 0, 0);
      n_vec++;
      if ({bus.count, bus.top_addr, bus.underflow, bus.empty} !== {4'd1, 12'h055, 1'b1, 1'b0}) begin
         n_miss++;
         $display("FAIL simul_empty got cnt=%0d top=%h u=%b e=%b want cnt=1 top=055 u=1 e=0",
                  bus.count, bus.top_addr, bus.underflow, bus.empty);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) apply(1, 0, 12'h300 + 12'(i), 0, 0);
      apply(1, 1, 12'h0AB, 0, 0);
      apply(1, 0, 12'h3FF, 1, 1);
      n_vec++;
      if ({bus.count, bus.empty, bus.top_addr, bus.overflow, bus.underflow} !==
          {4'd0, 1'b1, 12'h000, 1'b0, 1'b0}) begin
         n_miss++;
         $display("FAIL reset_mid got cnt=%0d e=%b top=%h o=%b u=%b want cnt=0 e=1 top=000 o=0 u=0",
                  bus.count, bus.empty, bus.top_addr, bus.overflow, bus.underflow);
      end
   endtask

   task automatic test_random();
      bit p, q, c, r;
      int sel;
      logic [AW-1:0] a, exp_pre;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 99));
         p = (sel < 55);
         q = (sel >= 40 && sel < 90);
         c = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 49) == 0);
         a = AW'($urandom_range(0, 4095));
         exp_pre = model_top();
         apply(p, q, a, c, r);
         if (q) begin
            n_vec++;
            if (pre_top !== exp_pre) begin
               n_miss++;
               $display("FAIL rnd_pop_top[%0d] got %h want %h", i, pre_top, exp_pre);
            end
         end
         n_vec++;
         if ({bus.count, bus.empty, bus.full, bus.overflow, bus.underflow, bus.top_addr} !==
             {4'(model_q.size()), model_q.size() == 0, model_q.size() == DP, m_ovf, m_unf, model_top()}) begin
            n_miss++;
            $display("FAIL rnd_state[%0d] got cnt=%0d e=%b f=%b o=%b u=%b top=%h want cnt=%0d o=%b u=%b top=%h",
                     i, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow, bus.top_addr,
                     model_q.size(), m_ovf, m_unf, model_top());
         end
      end
   endtask

   initial begin
      bus.push = 0; bus.pop = 0; bus.push_addr = '0; bus.err_clr = 0; rst = 1;
      @(posedge clk);
      #1;
      test_reset();
      test_lifo();
      test_full();
      test_empty();
      test_simul_empty();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
